// File: rtl/serial_rx_byte.sv
// serial_rx_byte
// ---------------------------------------------------------------------------
// Receives 8N1-style serial frames on a single idle-high wire and turns them
// into parallel bytes. The line is synchronised with two flops, a start bit is
// confirmed at its mid-point, and data and stop bits are sampled one bit
// period apart from there.
//
// Ports
//   clk        : single clock, rising edge
//   clear      : asynchronous active-high reset; discards any partial frame
//   d          : serial line, idle high, asynchronous to clk
//   data_out   : last correctly framed byte, held until the next good frame
//   valid      : one-cycle pulse on the edge that updates data_out
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : high whenever the receiver is not idle
//   state_dbg  : current receiver state, for observation only
// ---------------------------------------------------------------------------
module serial_rx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 d,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int PH_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  // Two-flop synchroniser. Both stages reset to the idle level so that a
  // release of clear never looks like a falling edge on the line.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Wait half a bit, then confirm the line is still low. A line that has
      // already gone high again was a glitch, not a start bit.
      S_START: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      // Each terminal count lands in the middle of a data bit. Shifting in
      // at the MSB and moving right leaves the first (LSB) bit at bit 0.
      S_DATA: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_STOP: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          bit_d   = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      // A low stop bit usually means a break or a stuck line; hold off until
      // the line is high again so the low level is not taken as a new start.
      S_WAIT_HIGH: begin
        phase_d = '0;
        bit_d   = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_rx_byte.sv
module tb_serial_rx_byte;

  localparam int N    = 16;
  localparam int H    = N / 2;
  localparam int DB   = 8;
  localparam int HIST = 8192;

  typedef enum {M_IDLE, M_FRAME, M_WAIT} mode_t;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          clear;
  logic          d;
  logic [DB-1:0] data_out;
  logic          valid;
  logic          frame_err;
  logic          busy;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_byte #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .clear     (clear),
    .d         (d),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------- line model
  // The model keeps the level driven on the line in every cycle and derives
  // the receiver's view from it: the line seen in cycle c is what was driven
  // in cycle c-2. Frames are then decoded by absolute sample times measured
  // from the cycle the low level is first seen.
  bit            d_hist [HIST];
  mode_t         mode = M_IDLE;
  int            t0 = 0;
  logic [DB-1:0] m_byte = '0;
  logic [DB-1:0] m_data = '0;
  logic [DB-1:0] pend_byte = '0;
  bit            pend_v = 1'b0;
  bit            pend_f = 1'b0;

  always @(negedge clk) begin
    bit rx;
    bit e_busy;
    bit e_valid;
    bit e_ferr;
    int k;
    if (cyc < HIST) d_hist[cyc] = clear ? 1'b1 : d;
    if (clear) begin
      mode   = M_IDLE;
      m_data = '0;
      pend_v = 1'b0;
      pend_f = 1'b0;
      check("rst_data",  int'(data_out),  0);
      check("rst_valid", int'(valid),     0);
      check("rst_ferr",  int'(frame_err), 0);
      check("rst_busy",  int'(busy),      0);
    end else begin
      // strobes decided in the previous cycle show up in this one
      e_valid = pend_v;
      e_ferr  = pend_f;
      if (pend_v) m_data = pend_byte;
      pend_v = 1'b0;
      pend_f = 1'b0;
      rx = (cyc >= 2 && cyc - 2 < HIST) ? d_hist[cyc-2] : 1'b1;
      e_busy = (mode != M_IDLE);
      case (mode)
        M_IDLE: begin
          if (!rx) begin
            mode = M_FRAME;
            t0   = cyc;
          end
        end
        M_FRAME: begin
          k = cyc - t0;
          if (k == H) begin
            if (rx) mode = M_IDLE;
          end else if (k == H + (DB + 1) * N) begin
            if (rx) begin
              pend_v    = 1'b1;
              pend_byte = m_byte;
              mode      = M_IDLE;
            end else begin
              pend_f = 1'b1;
              mode   = M_WAIT;
            end
          end else if (k > H && (k - H) % N == 0) begin
            m_byte[3'((k - H) / N - 1)] = rx;
          end
        end
        M_WAIT: begin
          if (rx) mode = M_IDLE;
        end
        default: mode = M_IDLE;
      endcase
      check("valid",     int'(valid),     int'(e_valid));
      check("frame_err", int'(frame_err), int'(e_ferr));
      check("busy",      int'(busy),      int'(e_busy));
      check("data_out",  int'(data_out),  int'(m_data));
    end
  end

  // -------------------------------------------------------------- scoreboard
  logic [DB-1:0] exp_q  [$];
  logic [DB-1:0] vdat_q [$];
  int            vcyc_q [$];
  int            ferr_cnt = 0;
  int            busy_cnt = 0;

  always @(negedge clk) begin
    if (!clear) begin
      if (valid) begin
        vcyc_q.push_back(cyc);
        vdat_q.push_back(data_out);
      end
      if (frame_err) ferr_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic reset_logs();
    exp_q.delete();
    vdat_q.delete();
    vcyc_q.delete();
    ferr_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic check_bytes(input string name);
    check({name, "_count"}, vdat_q.size(), exp_q.size());
    while (exp_q.size() > 0 && vdat_q.size() > 0) begin
      check({name, "_byte"}, int'(vdat_q.pop_front()), int'(exp_q.pop_front()));
    end
  endtask

  // ----------------------------------------------------------------- drivers
  task automatic drive_bits(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      d = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop,
                            output int tfall);
    @(posedge clk);
    #1;
    tfall = cyc;
    d = 1'b0;
    repeat (bclk - 1) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++) drive_bits(b[i], bclk);
    drive_bits(stop, bclk);
  endtask

  task automatic pulse_clear(input int n);
    @(posedge clk);
    #1;
    clear = 1'b1;
    d     = 1'b1;
    #1;
    check("clr_now_data",  int'(data_out),  0);
    check("clr_now_valid", int'(valid),     0);
    check("clr_now_ferr",  int'(frame_err), 0);
    check("clr_now_busy",  int'(busy),      0);
    repeat (n) @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int tf;
    int tf2;
    for (int i = 0; i < HIST; i++) d_hist[i] = 1'b1;
    clear = 1'b1;
    d     = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    clear = 1'b0;
    drive_bits(1'b1, 20);

    // 1: nominal byte; valid appears 2 (sync) + 8 + 9*16 + 1 = 155 cycles
    //    after the start bit is driven
    reset_logs();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, N, 1'b1, tf);
    drive_bits(1'b1, 30);
    check("t1_valid_cnt", vcyc_q.size(), 1);
    if (vcyc_q.size() >= 1) check("t1_valid_cyc", vcyc_q[0], tf + 155);
    check("t1_data", int'(data_out), 8'hA5);
    check("t1_ferr", ferr_cnt, 0);
    check_bytes("t1");

    // 2: start glitch, busy for exactly the half-bit check window
    reset_logs();
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 30);
    check("t2_valid_cnt", vcyc_q.size(), 0);
    check("t2_ferr", ferr_cnt, 0);
    check("t2_busy_cycles", busy_cnt, 8);
    check("t2_data", int'(data_out), 8'hA5);

    // 3: framing error followed by a long low period
    reset_logs();
    send_frame(8'h3C, N, 1'b0, tf);
    drive_bits(1'b0, 40);
    check("t3_busy_low", int'(busy), 1);
    drive_bits(1'b1, 30);
    check("t3_ferr", ferr_cnt, 1);
    check("t3_valid_cnt", vcyc_q.size(), 0);
    check("t3_data", int'(data_out), 8'hA5);
    check("t3_busy_after", int'(busy), 0);

    // 4: clear in the middle of data bit 3 of 0xFF, then a fresh frame
    reset_logs();
    drive_bits(1'b0, N);
    drive_bits(1'b1, 3 * N + 8);
    pulse_clear(4);
    drive_bits(1'b1, 10);
    reset_logs();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, N, 1'b1, tf);
    drive_bits(1'b1, 30);
    check("t4_data", int'(data_out), 8'h5A);
    check("t4_ferr", ferr_cnt, 0);
    check_bytes("t4");

    // 5: back-to-back frames, valids one frame (160 cycles) apart
    reset_logs();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, N, 1'b1, tf);
    send_frame(8'hFF, N, 1'b1, tf2);
    drive_bits(1'b1, 30);
    check("t5_valid_cnt", vcyc_q.size(), 2);
    if (vcyc_q.size() >= 2) check("t5_gap", vcyc_q[1] - vcyc_q[0], 160);
    if (vcyc_q.size() >= 1) check("t5_first_cyc", vcyc_q[0], tf + 155);
    check("t5_ferr", ferr_cnt, 0);
    check_bytes("t5");

    // 6: slow sender at 17 clocks per bit
    reset_logs();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 17, 1'b1, tf);
    drive_bits(1'b1, 40);
    check("t6_data", int'(data_out), 8'h81);
    check("t6_ferr", ferr_cnt, 0);
    check_bytes("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
